// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, funct codes, reset address and the nop word.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_JAL   = 6'h03;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  FUNCT_JR = 6'h08;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Branch target: word offset sign-extended and added to the fall-through PC.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_stage_npc_calc.sv
// Raw next-PC resolution for the instruction sitting in D; no validity or stall gating here.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] next_pc,
  output logic        taken,
  output logic        jump
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    next_pc = pc_plus4;
    taken   = 1'b0;
    jump    = 1'b0;
    case (opcode)
      OP_BEQ: begin
        taken   = (rs_data == rt_data);
        next_pc = branch_target(pc_plus4, instr[15:0]);
      end
      OP_BNE: begin
        taken   = (rs_data != rt_data);
        next_pc = branch_target(pc_plus4, instr[15:0]);
      end
      OP_J, OP_JAL: begin
        jump    = 1'b1;
        next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          jump    = 1'b1;
          next_pc = rs_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// IF/ID pipeline register with early branch/jump resolution and wrong-path squash.
module id_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] PC_value,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [31:0] next_PC,
  output logic        PCSrcD,
  output logic        j_sel,
  output logic        linkD
);

  logic [31:0] npc_raw;
  logic        taken_raw;
  logic        jump_raw;
  logic        decode_en;
  logic        redirect;

  assign PCPlus4D = PCD + 32'd4;
  assign rsD      = instrD[25:21];
  assign rtD      = instrD[20:16];

  npc_calc u_npc_calc (
    .instr    (instrD),
    .pc_plus4 (PCPlus4D),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .next_pc  (npc_raw),
    .taken    (taken_raw),
    .jump     (jump_raw)
  );

  // A stalled branch may be comparing stale operands, so nothing is issued until it unstalls.
  assign decode_en = validD & ~StallD;
  assign PCSrcD    = decode_en & taken_raw;
  assign j_sel     = decode_en & jump_raw;
  assign linkD     = decode_en & (instrD[31:26] == OP_JAL);
  assign redirect  = PCSrcD | j_sel;
  assign next_PC   = redirect ? npc_raw : PCPlus4D;

  // Priority: flush > stall > squash behind a redirect > normal load. Bubbles keep PCD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instrD <= NOP_WORD;
      PCD    <= RESET_PC;
      validD <= 1'b0;
    end else if (FlushD) begin
      instrD <= NOP_WORD;
      validD <= 1'b0;
    end else if (StallD) begin
      instrD <= instrD;
      validD <= validD;
    end else if (redirect) begin
      instrD <= NOP_WORD;
      validD <= 1'b0;
    end else begin
      instrD <= instruction;
      PCD    <= PC_value;
      validD <= 1'b1;
    end
  end

endmodule

// File: doc/id_stage.md
# id_stage

Decode-entry stage of the 5-stage MIPS pipeline, directly downstream of the instruction fetch unit. Captures the fetched instruction and its PC into the IF/ID pipeline register and resolves jumps and branches early, in the D stage. It drives the redirect signals (`next_PC`, `PCSrcD`, `j_sel`) back to the fetch unit and squashes the wrong-path instruction fetched behind a taken control transfer. The architecture has no branch delay slot.

## Interface
- `RESET_PC`, 32'h0000_3000: fetch reset address; `PCD` reset value.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `instruction` input 32: fetched word from the fetch unit, combinational on its PC.
- `PC_value` input 32: PC of `instruction`.
- `StallD` input 1: hold the IF/ID register (from the hazard unit).
- `FlushD` input 1: load a bubble into the IF/ID register (external flush).
- `rs_data` input 32: forwarded GPR[rs] for D-stage compare and `jr`.
- `rt_data` input 32: forwarded GPR[rt] for D-stage compare.
- `instrD` output 32: registered instruction; 0 (nop) when invalid.
- `PCD` output 32: registered PC.
- `PCPlus4D` output 32: `PCD` + 4.
- `validD` output 1: the IF/ID register holds a real instruction.
- `rsD`, `rtD` output 5: `instrD[25:21]`, `instrD[20:16]`, for the hazard unit.
- `next_PC` output 32: redirect target.
- `PCSrcD` output 1: taken conditional branch.
- `j_sel` output 1: unconditional jump (`j`, `jal`, `jr`).
- `linkD` output 1: `jal` in D; the link value is `PCPlus4D`.

## Operation
- IF/ID register update at each clock edge, highest priority first:
  - `FlushD`: load bubble (`validD`=0, `instrD`=0); `PCD` holds.
  - `StallD`: hold all state.
  - Redirect (`PCSrcD|j_sel`) currently asserted: load bubble. This squashes the wrong-path fetch.
  - Otherwise: load `instrD`←`instruction`, `PCD`←`PC_value`, `validD`←1.
- Decode uses opcode `instrD[31:26]`:
  - beq 6'h04: taken when `rs_data==rt_data`.
  - bne 6'h05: taken when `rs_data!=rt_data`.
  - j 6'h02 and jal 6'h03.
  - jr: opcode 0 with funct 6'h08.
- Targets:
  - Branch: `PCPlus4D + {{14{imm[15]}},imm,2'b00}`, modulo 2^32.
  - j/jal: `{PCPlus4D[31:28], instrD[25:0], 2'b00}`.
  - jr: `rs_data`.
- Output gating:
  - `PCSrcD`, `j_sel` and `linkD` are asserted only when `validD & ~StallD`.
  - `PCSrcD` and `j_sel` are never asserted together.
  - `next_PC` = selected target, or `PCPlus4D` when no redirect.
- Reset: `instrD`=0, `PCD`=`RESET_PC`, `validD`=0. All redirect outputs are 0 during reset and on the cycle after.

## Timing
- Latency: 1 cycle from `instruction` at IF to `instrD` in D.
- Redirect outputs are combinational from the D register and forwarded data, valid in the same cycle.
- Fetch unit takes `next_PC` at the following edge. The id_stage loads a bubble at that same edge.
- Taken-transfer penalty: exactly 1 bubble cycle.
- `StallD` during a pending branch (data hazard on `rs`/`rt`):
  - No redirect is issued.
  - The branch re-evaluates in the first unstalled cycle.
- `FlushD` together with `StallD`: flush wins.
- `FlushD` together with a redirect: the redirect is still issued that cycle, and a bubble is loaded.
- Reset asserted mid-operation: `validD` drops immediately (asynchronous) and any in-flight redirect is cancelled.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode constants: OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_RTYPE.
  - FUNCT_JR.
  - RESET_PC.
  - The NOP word.
- One combinational sub-module, `npc_calc`, takes `instrD`, `PCPlus4D`, `rs_data` and `rt_data`. It produces `next_PC`, the raw taken signal and the raw jump signal.
- id_stage owns the register, priority logic and gating.

## Test plan
- Reset: rst=0 → `validD`=0, `PCD`=0x3000, `instrD`=0, `PCSrcD`=`j_sel`=0.
- Sequential fetch of 0x3000/0x3004 (nop words) → `PCD` follows one cycle later, `PCPlus4D`=0x3004/0x3008, no redirect.
- `beq` at 0x3008 with imm=0x0003 and `rs_data==rt_data`=5:
  - `PCSrcD`=1 and `next_PC`=0x3018 in that cycle.
  - Next cycle `validD`=0; the following cycle `PCD`=0x3018.
- `bne` with imm=0xFFFE and equal operands → no redirect. With unequal operands, from PC 0x3010 → `next_PC`=0x300C.
- `jal` 0x0C000C00 at 0x3000 → `j_sel`=1, `linkD`=1, `next_PC`=0x00003000. `jr` with `rs_data`=0x3040 → `next_PC`=0x3040.
- `beq` held under `StallD`=1 for 2 cycles → `PCSrcD`=0 while stalled and 1 on release. `FlushD`+`StallD` together → bubble loaded.
